arm_mem_responder: RTL

Word-organised memory responder serving the ARM32 processor's instruction fetches and data loads/stores over a single valid/ready request/response channel. It replaces the bare `ram` array the processor currently indexes directly, which gives the core a real handshake, byte-enabled stores and a parameterised access latency. The processor is the only initiator. The storage array stays visible hierarchically as `mem` so benches can preload programs.

---
 rtl/arm_mem_responder_pkg.sv | 10 +
 rtl/arm_mem_responder_if.sv | 22 ++
 rtl/arm_mem_responder_array.sv | 22 ++
 rtl/arm_mem_responder.sv | 96 +++++++++
 4 files changed

// File: rtl/arm_mem_responder_pkg.sv
// arm_mem_pkg: shared state, alignment/error constants and byte-enable width helper for the ARM32 memory responder
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
  localparam logic ERR_OK = 1'b0;
  localparam logic ERR_FAULT = 1'b1;
  function automatic int be_width(input int n);
    return n / 8;
  endfunction
endpackage

// File: rtl/arm_mem_responder_if.sv
// arm_mem_responder_if: valid/ready request/response channel between the ARM32 core and its memory responder
interface arm_mem_responder_if import arm_mem_pkg::*; #(parameter int N = 32) ();
  localparam int BW = be_width(N);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [N-1:0]  req_addr;
  logic [N-1:0]  req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_rdata;
  logic          rsp_err;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/arm_mem_responder_array.sv
// arm_mem_array: word storage with a byte-enabled synchronous write port and an asynchronous read port
module arm_mem_array import arm_mem_pkg::*; #(
  parameter int N = 32,
  parameter int DEPTH = 1024,
  localparam int BW = be_width(N),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] widx_i,
  input  logic [N-1:0]  wdata_i,
  input  logic [BW-1:0] be_i,
  input  logic [AW-1:0] ridx_i,
  output logic [N-1:0]  rdata_o
);
  logic [N-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we_i)
      for (int i = 0; i < BW; i++)
        if (be_i[i]) mem[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
  assign rdata_o = mem[ridx_i];
endmodule

// File: rtl/arm_mem_responder.sv
// arm_mem_responder: single-outstanding memory responder with byte-enabled stores, fault checking and fixed access latency
module arm_mem_responder import arm_mem_pkg::*; #(
  parameter int N = 32,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic reset_n,
  arm_mem_responder_if.slave bus
);
  localparam int BW = be_width(N);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d, fault_q, fault_d, err_q, err_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [N-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
  logic [BW-1:0] be_q, be_d;
  logic          req_fault, commit, from_req, op_write, op_fault;
  logic [AW-1:0] op_idx;
  logic [N-1:0]  op_wdata, mem_rdata;
  logic [BW-1:0] op_be;
  assign req_fault = (bus.req_addr[1:0] & ALIGN_MASK) != 2'b00 || 64'(bus.req_addr) >= 64'(4 * DEPTH);
  // With zero latency the access completes on the accepting edge, so operands come straight from the bus
  assign from_req = state_q == IDLE;
  assign op_write = from_req ? bus.req_write : write_q;
  assign op_fault = from_req ? req_fault : fault_q;
  assign op_idx   = from_req ? bus.req_addr[AW+1:2] : idx_q;
  assign op_wdata = from_req ? bus.req_wdata : wdata_q;
  assign op_be    = from_req ? bus.req_be : be_q;
  assign commit   = state_q != RESP && state_d == RESP;
  assign rdata_d  = commit ? ((op_write || op_fault) ? '0 : mem_rdata) : rdata_q;
  assign err_d    = commit ? (op_fault ? ERR_FAULT : ERR_OK) : err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    fault_d = fault_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        write_d = bus.req_write;
        fault_d = req_fault;
        idx_d   = bus.req_addr[AW+1:2];
        wdata_d = bus.req_wdata;
        be_d    = bus.req_be;
        cnt_d   = LAT;
        state_d = LAT == 4'd0 ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? RESP : WAIT;
      end
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      fault_q <= fault_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  arm_mem_array #(.N(N), .DEPTH(DEPTH)) u_array (
    .clk    (clk),
    .we_i   (commit && op_write && !op_fault),
    .widx_i (op_idx),
    .wdata_i(op_wdata),
    .be_i   (op_be),
    .ridx_i (op_idx),
    .rdata_o(mem_rdata)
  );
  assign bus.req_ready = state_q == IDLE && reset_n;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule
